// File: rtl/afifo_pkg.sv
// Shared types and constants for the async FIFO read/write path adapters.
// The read-side output buffer occupancy is tracked with occ_state_e.
package afifo_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

    localparam int unsigned OCC_DEPTH = 2;

    function automatic int unsigned occ_level(input occ_state_e state);
        case (state)
            OCC_ONE: occ_level = 1;
            OCC_TWO: occ_level = 2;
            default: occ_level = 0;
        endcase
    endfunction

endpackage

// File: rtl/afifo_rd_skid_buf.sv
// Two-entry registered output buffer for the FIFO read stream.
// slot0 always drives the stream data; slot1 absorbs one word of overflow.
module afifo_rd_skid_buf
    import afifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  flush,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  full
);

    occ_state_e            state;
    occ_state_e            state_next;
    logic [DATA_WIDTH-1:0] slot0;
    logic [DATA_WIDTH-1:0] slot1;
    logic                  pop;
    logic                  load0_push;
    logic                  load0_shift;
    logic                  load1_push;

    assign valid = (state != OCC_EMPTY);
    assign data  = slot0;
    assign full  = (occ_level(state) == OCC_DEPTH);
    assign pop   = valid & ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OCC_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Flush wins over everything; a push is never honoured while full.
    always_comb begin
        state_next  = state;
        load0_push  = 1'b0;
        load0_shift = 1'b0;
        load1_push  = 1'b0;
        if (flush) begin
            state_next = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (push) begin
                        state_next = OCC_ONE;
                        load0_push = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (push && !pop) begin
                        state_next = OCC_TWO;
                        load1_push = 1'b1;
                    end else if (push && pop) begin
                        load0_push = 1'b1;
                    end else if (pop) begin
                        state_next = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        state_next  = OCC_ONE;
                        load0_shift = 1'b1;
                    end
                end
                default: begin
                    state_next = OCC_EMPTY;
                end
            endcase
        end
    end

    // Slots only move on a load, so data stays put under backpressure and after a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            if (load0_push) begin
                slot0 <= push_data;
            end else if (load0_shift) begin
                slot0 <= slot1;
            end
            if (load1_push) begin
                slot1 <= push_data;
            end
        end
    end

endmodule

// File: rtl/afifo_rd_stream_adapter.sv
// Read-domain adapter: drains the FIFO read port into a valid/ready stream,
// with a read-enable gate, synchronous flush and a free-running pop counter.
module afifo_rd_stream_adapter
    import afifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    input  logic                  en,
    input  logic                  flush,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  pop_count
);

    if (ADDR_WIDTH < 1 || DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_params
        $error("afifo_rd_stream_adapter: widths must be at least 1");
    end

    logic buf_full;

    // Pops are held off during reset since the buffer could not capture the word.
    // The pop decision depends only on buffer occupancy, never on m_ready.
    assign rinc = rrst_n & en & ~flush & ~rempty & ~buf_full;

    afifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk       (rclk),
        .rst_n     (rrst_n),
        .push      (rinc),
        .push_data (rdata),
        .flush     (flush),
        .ready     (m_ready),
        .valid     (m_valid),
        .data      (m_data),
        .full      (buf_full)
    );

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            pop_count <= '0;
        end else if (rinc) begin
            pop_count <= pop_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_afifo_rd_stream_adapter.sv
// Directed bench for afifo_rd_stream_adapter with a queue-based FIFO read port model.
// A second instance with a 4-bit counter shares all inputs to exercise counter wrap.
module tb_afifo_rd_stream_adapter;

    logic        rclk = 1'b0;
    logic        rrst_n;
    logic        rempty;
    logic [31:0] rdata;
    logic        rinc;
    logic        en;
    logic        flush;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready;
    logic [15:0] pop_count;

    logic        rinc_n;
    logic        m_valid_n;
    logic [31:0] m_data_n;
    logic [3:0]  pop_count_n;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] fifo[$];
    logic [31:0] seen[$];

    always #5 rclk = ~rclk;

    afifo_rd_stream_adapter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .CNT_WIDTH(16)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .en(en), .flush(flush), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .pop_count(pop_count)
    );

    afifo_rd_stream_adapter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .CNT_WIDTH(4)) dut_narrow (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc_n),
        .en(en), .flush(flush), .m_valid(m_valid_n), .m_data(m_data_n), .m_ready(m_ready),
        .pop_count(pop_count_n)
    );

    function automatic void refresh_fifo();
        rempty = (fifo.size() == 0);
        rdata  = rempty ? 32'h0 : fifo[0];
    endfunction

    // One clock: pop decision sampled at negedge, model updated just after posedge.
    task automatic tick();
        logic do_pop;
        @(negedge rclk);
        do_pop = rinc;
        @(posedge rclk);
        #1;
        if (do_pop && fifo.size() > 0) void'(fifo.pop_front());
        refresh_fifo();
        #1;
    endtask

    always @(negedge rclk) begin
        vectors++;
        assert (!(rinc && rempty)) else begin
            $display("[TB] FAIL rinc_while_empty: rinc=%b rempty=%b", rinc, rempty);
            miscompares++;
        end
        vectors++;
        if ({rinc_n, m_valid_n, m_data_n} !== {rinc, m_valid, m_data}) begin
            $display("[TB] FAIL narrow_vs_wide: got %b/%b/%h required %b/%b/%h",
                     rinc_n, m_valid_n, m_data_n, rinc, m_valid, m_data);
            miscompares++;
        end
        if (rrst_n && m_valid && m_ready) seen.push_back(m_data);
    end

    task automatic test_reset();
        #2;
        vectors++; if (m_valid !== 1'b0 || m_data !== 32'h0) begin $display("[TB] FAIL reset_out: got %b/%h required 0/0", m_valid, m_data); miscompares++; end
        vectors++; if (pop_count !== 16'd0 || rinc !== 1'b0) begin $display("[TB] FAIL reset_cnt: got %h/%b required 0/0", pop_count, rinc); miscompares++; end
        @(posedge rclk); @(posedge rclk); #2;
        rrst_n = 1'b1;
        #1;
        vectors++; if (m_valid !== 1'b0 || pop_count_n !== 4'd0) begin $display("[TB] FAIL reset_release: got %b/%h required 0/0", m_valid, pop_count_n); miscompares++; end
    endtask

    task automatic test_counter_wrap();
        seen.delete();
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) fifo.push_back(32'h100 + 32'(i));
        refresh_fifo(); #1;
        for (int k = 0; k < 15; k++) tick();
        vectors++; if (pop_count_n !== 4'd15 || pop_count !== 16'd15) begin $display("[TB] FAIL wrap_15: got %h/%h required f/000f", pop_count_n, pop_count); miscompares++; end
        tick();
        vectors++; if (pop_count_n !== 4'd0 || pop_count !== 16'd16) begin $display("[TB] FAIL wrap_16: got %h/%h required 0/0010", pop_count_n, pop_count); miscompares++; end
        tick();
        vectors++; if (pop_count_n !== 4'd1 || pop_count !== 16'd17) begin $display("[TB] FAIL wrap_17: got %h/%h required 1/0011", pop_count_n, pop_count); miscompares++; end
        vectors++; if (m_data !== 32'h110 || rinc !== 1'b0) begin $display("[TB] FAIL wrap_last: got %h/%b required 00000110/0", m_data, rinc); miscompares++; end
        tick();
        vectors++; if (m_valid !== 1'b0 || seen.size() != 17) begin $display("[TB] FAIL wrap_drain: got %b/%0d required 0/17", m_valid, seen.size()); miscompares++; end
    endtask

    task automatic test_streaming();
        seen.delete();
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) fifo.push_back(32'(i));
        refresh_fifo(); #1;
        vectors++; if (rinc !== 1'b1 || m_valid !== 1'b0) begin $display("[TB] FAIL stream_start: got %b/%b required 1/0", rinc, m_valid); miscompares++; end
        for (int i = 1; i <= 16; i++) begin
            tick();
            vectors++; if (m_valid !== 1'b1 || m_data !== 32'(i)) begin $display("[TB] FAIL stream_data: got %b/%h required 1/%h", m_valid, m_data, 32'(i)); miscompares++; end
        end
        vectors++; if (rinc !== 1'b0 || pop_count !== 16'd33 || pop_count_n !== 4'd1) begin $display("[TB] FAIL stream_count: got %b/%0d/%0d required 0/33/1", rinc, pop_count, pop_count_n); miscompares++; end
        tick();
        vectors++; if (m_valid !== 1'b0) begin $display("[TB] FAIL stream_drain: got %b required 0", m_valid); miscompares++; end
        vectors++; if (seen.size() != 16) begin $display("[TB] FAIL stream_seen_size: got %0d required 16", seen.size()); miscompares++; end
        for (int i = 0; i < 16 && i < seen.size(); i++) begin
            vectors++; if (seen[i] !== 32'(i + 1)) begin $display("[TB] FAIL stream_order: got %h required %h", seen[i], 32'(i + 1)); miscompares++; end
        end
    endtask

    task automatic test_backpressure();
        seen.delete();
        m_ready = 1'b0;
        fifo.push_back(32'hA); fifo.push_back(32'hB); fifo.push_back(32'hC);
        refresh_fifo(); #1;
        tick();
        vectors++; if (m_data !== 32'hA || rinc !== 1'b1) begin $display("[TB] FAIL bp_first: got %h/%b required a/1", m_data, rinc); miscompares++; end
        tick();
        vectors++; if (m_data !== 32'hA || rinc !== 1'b0) begin $display("[TB] FAIL bp_full: got %h/%b required a/0", m_data, rinc); miscompares++; end
        tick();
        vectors++; if (m_valid !== 1'b1 || m_data !== 32'hA || rinc !== 1'b0) begin $display("[TB] FAIL bp_hold: got %b/%h/%b required 1/a/0", m_valid, m_data, rinc); miscompares++; end
        vectors++; if (fifo.size() != 1 || pop_count !== 16'd35) begin $display("[TB] FAIL bp_pops: got %0d/%0d required 1/35", fifo.size(), pop_count); miscompares++; end
        m_ready = 1'b1;
        tick();
        vectors++; if (m_data !== 32'hB || rinc !== 1'b1) begin $display("[TB] FAIL bp_release: got %h/%b required b/1", m_data, rinc); miscompares++; end
        tick();
        vectors++; if (m_data !== 32'hC) begin $display("[TB] FAIL bp_c: got %h required c", m_data); miscompares++; end
        tick();
        vectors++; if (m_valid !== 1'b0 || pop_count !== 16'd36) begin $display("[TB] FAIL bp_end: got %b/%0d required 0/36", m_valid, pop_count); miscompares++; end
        vectors++; if (seen.size() != 3 || seen[0] !== 32'hA || seen[1] !== 32'hB || seen[2] !== 32'hC) begin $display("[TB] FAIL bp_order: got %0d words required a,b,c", seen.size()); miscompares++; end
    endtask

    task automatic test_flush();
        seen.delete();
        m_ready = 1'b0;
        fifo.push_back(32'h5); fifo.push_back(32'h6); fifo.push_back(32'h7);
        refresh_fifo(); #1;
        tick(); tick();
        vectors++; if (m_data !== 32'h5 || fifo.size() != 1) begin $display("[TB] FAIL flush_setup: got %h/%0d required 5/1", m_data, fifo.size()); miscompares++; end
        flush = 1'b1; #1;
        vectors++; if (rinc !== 1'b0) begin $display("[TB] FAIL flush_rinc_two: got %b required 0", rinc); miscompares++; end
        tick();
        flush = 1'b0; #1;
        vectors++; if (m_valid !== 1'b0 || m_data !== 32'h5 || rinc !== 1'b1) begin $display("[TB] FAIL flush_empty: got %b/%h/%b required 0/5/1", m_valid, m_data, rinc); miscompares++; end
        m_ready = 1'b1;
        tick();
        vectors++; if (m_valid !== 1'b1 || m_data !== 32'h7) begin $display("[TB] FAIL flush_next: got %b/%h required 1/7", m_valid, m_data); miscompares++; end
        tick();
        m_ready = 1'b0;
        fifo.push_back(32'h8); fifo.push_back(32'h9);
        refresh_fifo(); #1;
        tick();
        m_ready = 1'b1; flush = 1'b1; #1;
        vectors++; if (rinc !== 1'b0 || m_data !== 32'h8) begin $display("[TB] FAIL flush_rinc_one: got %b/%h required 0/8", rinc, m_data); miscompares++; end
        tick();
        flush = 1'b0; #1;
        vectors++; if (m_valid !== 1'b0 || fifo.size() != 1) begin $display("[TB] FAIL flush_one_empty: got %b/%0d required 0/1", m_valid, fifo.size()); miscompares++; end
        tick(); tick();
        vectors++; if (m_valid !== 1'b0 || pop_count !== 16'd41) begin $display("[TB] FAIL flush_count: got %b/%0d required 0/41", m_valid, pop_count); miscompares++; end
        vectors++; if (seen.size() != 3 || seen[0] !== 32'h7 || seen[1] !== 32'h8 || seen[2] !== 32'h9) begin $display("[TB] FAIL flush_order: got %0d words required 7,8,9", seen.size()); miscompares++; end
    endtask

    task automatic test_gate();
        seen.delete();
        m_ready = 1'b0;
        fifo.push_back(32'h20); fifo.push_back(32'h21);
        refresh_fifo(); #1;
        tick();
        en = 1'b0; #1;
        vectors++; if (rinc !== 1'b0 || m_data !== 32'h20) begin $display("[TB] FAIL gate_rinc: got %b/%h required 0/20", rinc, m_data); miscompares++; end
        m_ready = 1'b1;
        tick();
        vectors++; if (m_valid !== 1'b0 || rinc !== 1'b0 || fifo.size() != 1) begin $display("[TB] FAIL gate_drain: got %b/%b/%0d required 0/0/1", m_valid, rinc, fifo.size()); miscompares++; end
        tick();
        vectors++; if (pop_count !== 16'd42) begin $display("[TB] FAIL gate_count: got %0d required 42", pop_count); miscompares++; end
        en = 1'b1; #1;
        vectors++; if (rinc !== 1'b1) begin $display("[TB] FAIL gate_reopen: got %b required 1", rinc); miscompares++; end
        tick();
        vectors++; if (m_data !== 32'h21) begin $display("[TB] FAIL gate_data: got %h required 21", m_data); miscompares++; end
        tick();
        vectors++; if (seen.size() != 2 || seen[0] !== 32'h20 || seen[1] !== 32'h21 || pop_count !== 16'd43) begin $display("[TB] FAIL gate_order: got %0d words count %0d required 2/43", seen.size(), pop_count); miscompares++; end
    endtask

    task automatic test_reset_midstream();
        seen.delete();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo.push_back(32'h30 + 32'(i));
        refresh_fifo(); #1;
        tick(); tick();
        vectors++; if (m_valid !== 1'b1 || rinc !== 1'b0 || m_data !== 32'h30) begin $display("[TB] FAIL mid_setup: got %b/%b/%h required 1/0/30", m_valid, rinc, m_data); miscompares++; end
        rrst_n = 1'b0; #1;
        vectors++; if (m_valid !== 1'b0 || rinc !== 1'b0 || m_data !== 32'h0) begin $display("[TB] FAIL mid_async: got %b/%b/%h required 0/0/0", m_valid, rinc, m_data); miscompares++; end
        vectors++; if (pop_count !== 16'd0 || pop_count_n !== 4'd0) begin $display("[TB] FAIL mid_count: got %0d/%0d required 0/0", pop_count, pop_count_n); miscompares++; end
        tick();
        vectors++; if (fifo.size() != 2 || rinc !== 1'b0) begin $display("[TB] FAIL mid_held: got %0d/%b required 2/0", fifo.size(), rinc); miscompares++; end
        rrst_n = 1'b1; m_ready = 1'b1; #1;
        tick();
        vectors++; if (m_data !== 32'h32) begin $display("[TB] FAIL mid_resume: got %h required 32", m_data); miscompares++; end
        tick();
        vectors++; if (m_data !== 32'h33) begin $display("[TB] FAIL mid_next: got %h required 33", m_data); miscompares++; end
        tick();
        vectors++; if (m_valid !== 1'b0 || pop_count !== 16'd2 || seen.size() != 2 || seen[0] !== 32'h32) begin $display("[TB] FAIL mid_end: got %b/%0d/%0d required 0/2/2", m_valid, pop_count, seen.size()); miscompares++; end
    endtask

    initial begin
        rrst_n  = 1'b0;
        en      = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b1;
        fifo.delete();
        refresh_fifo();
        test_reset();
        test_counter_wrap();
        test_streaming();
        test_backpressure();
        test_flush();
        test_gate();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
